// File: rtl/button_event_scheduler_pkg.sv
// Shared event codes, widths and helpers for the button event scheduler.
package button_event_scheduler_pkg;

  localparam int EVT_W               = 2;
  localparam int NUM_EVT             = 3;
  localparam int DEFAULT_LONG_CYCLES = 25000000;

  localparam logic [EVT_W-1:0] EVT_PRESS   = 2'd0;
  localparam logic [EVT_W-1:0] EVT_LONG    = 2'd1;
  localparam logic [EVT_W-1:0] EVT_RELEASE = 2'd2;

  // Highest-priority pending type of one button; PRESS before LONG before
  // RELEASE keeps the per-button event order intact.
  function automatic logic [EVT_W-1:0] first_evt(input logic [NUM_EVT-1:0] bits);
    if (bits[EVT_PRESS]) return EVT_PRESS;
    if (bits[EVT_LONG])  return EVT_LONG;
    return EVT_RELEASE;
  endfunction

endpackage

// File: rtl/btn_event_detect.sv
// Per-button edge and long-hold detector producing single-cycle event pulses.
module btn_event_detect #(
  parameter int LONG_CYCLES = 25000000,
  parameter int CTR_W       = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic press_o,
  output logic long_o,
  output logic release_o
);

  localparam logic [CTR_W-1:0] CNT_LAST = CTR_W'(LONG_CYCLES - 1);
  localparam logic [CTR_W-1:0] CNT_PRE  = CTR_W'(LONG_CYCLES - 2);

  logic             prev_q;
  logic [CTR_W-1:0] cnt_q, cnt_d;

  // Hold counter: cleared while released, counts up while held, then parks
  // at its last value so the long pulse cannot repeat within one press.
  always_comb begin
    cnt_d = cnt_q;
    if (!level_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Level history and hold counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= level_i;
      cnt_q  <= cnt_d;
    end
  end

  assign press_o   = level_i & ~prev_q;
  assign release_o = ~level_i & prev_q;
  // Fires in the cycle whose increment brings the counter to its last value.
  assign long_o    = level_i & (cnt_q == CNT_PRE);

endmodule

// File: rtl/button_event_scheduler.sv
// Turns NUM_BTN debounced levels into PRESS/LONG/RELEASE events and
// serialises them onto one valid/ready port with round-robin arbitration.
module button_event_scheduler
  import button_event_scheduler_pkg::*;
#(
  parameter int NUM_BTN     = 4,
  parameter int LONG_CYCLES = DEFAULT_LONG_CYCLES,
  parameter int CTR_W       = 25,
  parameter int ID_W        = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] btn_level_i,
  output logic               evt_valid_o,
  input  logic               evt_ready_i,
  output logic [ID_W-1:0]    evt_id_o,
  output logic [EVT_W-1:0]   evt_type_o,
  output logic               overflow_o,
  input  logic               clr_overflow_i
);

  logic [NUM_BTN-1:0] det_press, det_long, det_rel;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_det
    btn_event_detect #(
      .LONG_CYCLES (LONG_CYCLES),
      .CTR_W       (CTR_W)
    ) u_det (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .level_i   (btn_level_i[g]),
      .press_o   (det_press[g]),
      .long_o    (det_long[g]),
      .release_o (det_rel[g])
    );
  end

  logic [NUM_BTN-1:0][NUM_EVT-1:0] pend_q, pend_d;
  logic                            evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]                 evt_id_q, evt_id_d;
  logic [EVT_W-1:0]                evt_type_q, evt_type_d;
  logic [ID_W-1:0]                 rr_q, rr_d;
  logic                            overflow_q, overflow_d;

  logic                            accept, load;
  logic [NUM_EVT-1:0]              type_mask;

  assign accept    = evt_valid_q & evt_ready_i;
  assign load      = ~evt_valid_q | evt_ready_i;
  assign type_mask = NUM_EVT'(1) << evt_type_q;

  logic               found_hi, found_lo, win_found;
  logic [ID_W-1:0]    hi_id, lo_id, win_id;
  logic [NUM_EVT-1:0] hi_bits, lo_bits, win_bits, row;

  // Round-robin search: first candidate above rr wins, else the first one
  // from index 0 (the wrap). The presented event is masked out so it is not
  // granted twice while it waits for acceptance.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    hi_bits  = '0;
    lo_bits  = '0;
    row      = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      row = pend_q[i];
      if (evt_valid_q && (evt_id_q == ID_W'(i))) begin
        row = row & ~type_mask;
      end
      if (|row) begin
        if (!found_hi && (i > int'(rr_q))) begin
          found_hi = 1'b1;
          hi_id    = ID_W'(i);
          hi_bits  = row;
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          lo_id    = ID_W'(i);
          lo_bits  = row;
        end
      end
    end
    win_found = found_lo;
    win_id    = found_hi ? hi_id : lo_id;
    win_bits  = found_hi ? hi_bits : lo_bits;
  end

  logic               merge, clr_bit;
  logic [NUM_EVT-1:0] evs;

  // Pending array: new events set, accepted event clears; a set that lands
  // on an already-pending bit not being cleared this cycle is a merge.
  always_comb begin
    pend_d  = pend_q;
    merge   = 1'b0;
    clr_bit = 1'b0;
    evs     = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      evs              = '0;
      evs[EVT_PRESS]   = det_press[i];
      evs[EVT_LONG]    = det_long[i];
      evs[EVT_RELEASE] = det_rel[i];
      for (int t = 0; t < NUM_EVT; t++) begin
        clr_bit = accept && (evt_id_q == ID_W'(i)) && (evt_type_q == EVT_W'(t));
        if (evs[t]) begin
          if (pend_q[i][t] && !clr_bit) merge = 1'b1;
          pend_d[i][t] = 1'b1;
        end else if (clr_bit) begin
          pend_d[i][t] = 1'b0;
        end
      end
    end
  end

  // Output register load, round-robin pointer and sticky overflow.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_type_d  = evt_type_q;
    rr_d        = rr_q;
    if (load) begin
      evt_valid_d = win_found;
      if (win_found) begin
        evt_id_d   = win_id;
        evt_type_d = first_evt(win_bits);
        rr_d       = win_id;
      end
    end
    if (merge) begin
      overflow_d = 1'b1;
    end else if (clr_overflow_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers; reset discards any presented event immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_type_q  <= EVT_PRESS;
      rr_q        <= ID_W'(NUM_BTN - 1);
      overflow_q  <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_type_q  <= evt_type_d;
      rr_q        <= rr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_id_o    = evt_id_q;
  assign evt_type_o  = evt_type_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: directed scenarios plus randomized
// traffic, all compared against a behavioural event model.
module tb_button_event_scheduler;
  import button_event_scheduler_pkg::*;

  localparam int NB = 4;
  localparam int LC = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NB-1:0] btn_level_i;
  logic          evt_valid_o;
  logic          evt_ready_i;
  logic [1:0]    evt_id_o;
  logic [1:0]    evt_type_o;
  logic          overflow_o;
  logic          clr_overflow_i;

  button_event_scheduler #(
    .NUM_BTN     (NB),
    .LONG_CYCLES (LC),
    .CTR_W       (4),
    .ID_W        (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .btn_level_i    (btn_level_i),
    .evt_valid_o    (evt_valid_o),
    .evt_ready_i    (evt_ready_i),
    .evt_id_o       (evt_id_o),
    .evt_type_o     (evt_type_o),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_overflow_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model: run lengths of held levels, pending event flags,
  // presented event and sticky overflow.
  int run_len [NB];
  bit m_prev  [NB];
  bit m_pend  [NB][3];
  bit m_valid;
  int m_id, m_type, m_rr;
  bit m_ovf;

  typedef struct {
    int id;
    int typ;
    int cyc;
  } ev_t;
  ev_t log_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      run_len[i] = 0;
      m_prev[i]  = 1'b0;
      for (int t = 0; t < 3; t++) m_pend[i][t] = 1'b0;
    end
    m_valid = 1'b0;
    m_id    = 0;
    m_type  = 0;
    m_rr    = NB - 1;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step();
    bit ev [NB][3];
    bit acc, found, merged, lvl, clr;
    int w_id, w_type, j;
    acc    = m_valid && evt_ready_i;
    found  = 1'b0;
    merged = 1'b0;
    w_id   = 0;
    w_type = 0;
    for (int i = 0; i < NB; i++) begin
      lvl      = btn_level_i[i];
      ev[i][0] = lvl && !m_prev[i];
      ev[i][1] = lvl && (run_len[i] + 1 == LC - 1);
      ev[i][2] = !lvl && m_prev[i];
    end
    for (int k = 1; k <= NB; k++) begin
      j = (m_rr + k) % NB;
      for (int t = 0; t < 3; t++) begin
        if (!found && m_pend[j][t] && !(m_valid && j == m_id && t == m_type)) begin
          found  = 1'b1;
          w_id   = j;
          w_type = t;
        end
      end
    end
    for (int i = 0; i < NB; i++) begin
      for (int t = 0; t < 3; t++) begin
        clr = acc && i == m_id && t == m_type;
        if (ev[i][t]) begin
          if (m_pend[i][t] && !clr) merged = 1'b1;
          m_pend[i][t] = 1'b1;
        end else if (clr) begin
          m_pend[i][t] = 1'b0;
        end
      end
    end
    if (merged) m_ovf = 1'b1;
    else if (clr_overflow_i) m_ovf = 1'b0;
    if (!m_valid || evt_ready_i) begin
      m_valid = found;
      if (found) begin
        m_id   = w_id;
        m_type = w_type;
        m_rr   = w_id;
      end
    end
    for (int i = 0; i < NB; i++) begin
      lvl = btn_level_i[i];
      if (!lvl) run_len[i] = 0;
      else if (run_len[i] < 1000) run_len[i] = run_len[i] + 1;
      m_prev[i] = lvl;
    end
  endtask

  task automatic step();
    if (!rst_i && evt_valid_o && evt_ready_i)
      log_q.push_back('{id: int'(evt_id_o), typ: int'(evt_type_o), cyc: cyc});
    @(posedge clk_i);
    if (rst_i) model_reset();
    else model_step();
    cyc++;
    #1;
    chk("valid", int'(evt_valid_o), int'(m_valid));
    if (m_valid) begin
      chk("id", int'(evt_id_o), m_id);
      chk("type", int'(evt_type_o), m_type);
    end
    chk("overflow", int'(overflow_o), int'(m_ovf));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_valid", int'(evt_valid_o), 0);
    chk("rst_id", int'(evt_id_o), 0);
    chk("rst_type", int'(evt_type_o), 0);
    chk("rst_ovf", int'(overflow_o), 0);
    model_reset();
    steps(2);
    rst_i = 1'b0;
    log_q.delete();
  endtask

  task automatic chk_entry(input string tag, input int idx, input int id, input int typ, input int dcyc, input int k);
    if (idx < log_q.size()) begin
      chk({tag, "_id"}, log_q[idx].id, id);
      chk({tag, "_type"}, log_q[idx].typ, typ);
      if (dcyc >= 0) chk({tag, "_cyc"}, log_q[idx].cyc - k, dcyc);
    end else begin
      chk({tag, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    int k;
    int seq0[$];
    int seq3[$];
    rst_i          = 1'b0;
    btn_level_i    = '0;
    evt_ready_i    = 1'b1;
    clr_overflow_i = 1'b0;
    model_reset();
    #2;
    do_reset();

    // 1: reset in the middle of an event, levels low afterwards
    btn_level_i = 4'b0010;
    steps(2);
    btn_level_i = '0;
    steps(1);
    do_reset();
    steps(10);
    chk("t1_no_events", log_q.size(), 0);

    // 2: short tap on button 2
    log_q.delete();
    k = cyc;
    btn_level_i = 4'b0100;
    steps(3);
    btn_level_i = '0;
    steps(10);
    chk("t2_count", log_q.size(), 2);
    chk_entry("t2_press", 0, 2, 0, 2, k);
    chk_entry("t2_release", 1, 2, 2, 5, k);

    // 3: long hold on button 1
    log_q.delete();
    k = cyc;
    btn_level_i = 4'b0010;
    steps(20);
    btn_level_i = '0;
    steps(10);
    chk("t3_count", log_q.size(), 3);
    chk_entry("t3_press", 0, 1, 0, 2, k);
    chk_entry("t3_long", 1, 1, 1, 8, k);
    chk_entry("t3_release", 2, 1, 2, 22, k);

    // 4: simultaneous rises from reset pointer, then from pointer 1
    do_reset();
    k = cyc;
    btn_level_i = 4'b1111;
    steps(4);
    btn_level_i = '0;
    steps(12);
    chk("t4a_count", log_q.size(), 8);
    for (int i = 0; i < 4; i++) chk_entry("t4a_press", i, i, 0, 2 + i, k);
    btn_level_i = 4'b0010;
    steps(2);
    btn_level_i = '0;
    steps(8);
    log_q.delete();
    k = cyc;
    btn_level_i = 4'b1111;
    steps(4);
    btn_level_i = '0;
    steps(12);
    for (int i = 0; i < 4; i++) chk_entry("t4b_press", i, (i + 2) % 4, 0, 2 + i, k);

    // 5: stalled consumer with a second tap merging into pending events
    log_q.delete();
    evt_ready_i = 1'b0;
    btn_level_i = 4'b0001;
    steps(2);
    btn_level_i = '0;
    steps(2);
    btn_level_i = 4'b0001;
    steps(2);
    btn_level_i = '0;
    steps(4);
    chk("t5_valid", int'(evt_valid_o), 1);
    chk("t5_id", int'(evt_id_o), 0);
    chk("t5_type", int'(evt_type_o), 0);
    chk("t5_ovf", int'(overflow_o), 1);
    evt_ready_i = 1'b1;
    steps(6);
    chk("t5_count", log_q.size(), 2);
    chk_entry("t5_press", 0, 0, 0, -1, 0);
    chk_entry("t5_release", 1, 0, 2, -1, 0);
    clr_overflow_i = 1'b1;
    steps(1);
    clr_overflow_i = 1'b0;
    chk("t5_ovf_clr", int'(overflow_o), 0);

    // 6: toggling ready while buttons 0 and 3 hold and release
    log_q.delete();
    btn_level_i = 4'b1001;
    for (int i = 0; i < 14; i++) begin
      evt_ready_i = i[0];
      step();
    end
    btn_level_i = '0;
    for (int i = 0; i < 20; i++) begin
      evt_ready_i = i[0];
      step();
    end
    evt_ready_i = 1'b1;
    steps(5);
    foreach (log_q[i]) begin
      if (log_q[i].id == 0) seq0.push_back(log_q[i].typ);
      if (log_q[i].id == 3) seq3.push_back(log_q[i].typ);
    end
    chk("t6_total", log_q.size(), 6);
    chk("t6_b0_count", seq0.size(), 3);
    chk("t6_b3_count", seq3.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < seq0.size()) chk("t6_b0_order", seq0[i], i);
      if (i < seq3.size()) chk("t6_b3_order", seq3[i], i);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 5) == 0) btn_level_i[i] = ~btn_level_i[i];
      evt_ready_i    = ($urandom_range(0, 3) != 0);
      clr_overflow_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      else step();
    end
    btn_level_i    = '0;
    evt_ready_i    = 1'b1;
    clr_overflow_i = 1'b0;
    steps(20);
    chk("drain_idle", int'(evt_valid_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
